// File: rtl/axi_ic_pkg.sv
// ============================================================================
// Module   : axi_ic_pkg
// Brief    : Shared AXI interconnect field widths, defaults and AR FSM states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_ic_pkg;

    localparam int c_mst_amt           = 2;
    localparam int c_slv_amt           = 1;
    localparam int c_data_width        = 32;
    localparam int c_addr_width        = 32;
    localparam int c_trans_mst_id_w    = 5;
    localparam int c_trans_burst_w     = 2;
    localparam int c_trans_data_len_w  = 3;
    localparam int c_trans_data_size_w = 3;

    localparam logic [1:0] c_burst_fixed = 2'b00;
    localparam logic [1:0] c_burst_incr  = 2'b01;
    localparam logic [1:0] c_burst_wrap  = 2'b10;

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_HOLD = 1'b1
    } ar_state_t;

endpackage

`default_nettype wire

// File: rtl/sa_outst_fifo.sv
// ============================================================================
// Module   : sa_outst_fifo
// Brief    : Synchronous FIFO holding the master index of each in-flight read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sa_outst_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

`default_nettype wire

// File: rtl/sa_read_channel.sv
// ============================================================================
// Module   : sa_read_channel
// Brief    : Slave-side AR arbiter with in-order R routing back to dispatchers.
//            SA_RR_ARB_EN selects round-robin; otherwise fixed lowest-index priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sa_read_channel
    import axi_ic_pkg::*;
#(
    parameter int MST_AMT           = c_mst_amt,
    parameter int OUTSTANDING_AMT   = 8,
    parameter int DATA_WIDTH        = c_data_width,
    parameter int ADDR_WIDTH        = c_addr_width,
    parameter int TRANS_MST_ID_W    = c_trans_mst_id_w,
    parameter int TRANS_BURST_W     = c_trans_burst_w,
    parameter int TRANS_DATA_LEN_W  = c_trans_data_len_w,
    parameter int TRANS_DATA_SIZE_W = c_trans_data_size_w,
    parameter int MST_ID_W          = (MST_AMT > 1) ? $clog2(MST_AMT) : 1
) (
    input  logic                                  ACLK_i,
    input  logic                                  ARESET_i,
    input  logic [TRANS_MST_ID_W*MST_AMT-1:0]     dsp_ARID_i,
    input  logic [ADDR_WIDTH*MST_AMT-1:0]         dsp_ARADDR_i,
    input  logic [TRANS_BURST_W*MST_AMT-1:0]      dsp_ARBURST_i,
    input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]   dsp_ARLEN_i,
    input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]  dsp_ARSIZE_i,
    input  logic [MST_AMT-1:0]                    dsp_ARVALID_i,
    input  logic [MST_AMT-1:0]                    dsp_AR_outst_full_i,
    output logic [MST_AMT-1:0]                    dsp_ARREADY_o,
    output logic [TRANS_MST_ID_W*MST_AMT-1:0]     dsp_RID_o,
    output logic [DATA_WIDTH*MST_AMT-1:0]         dsp_RDATA_o,
    output logic [MST_AMT-1:0]                    dsp_RLAST_o,
    output logic [MST_AMT-1:0]                    dsp_RVALID_o,
    input  logic [MST_AMT-1:0]                    dsp_RREADY_i,
    output logic [TRANS_MST_ID_W-1:0]             s_ARID_o,
    output logic [ADDR_WIDTH-1:0]                 s_ARADDR_o,
    output logic [TRANS_BURST_W-1:0]              s_ARBURST_o,
    output logic [TRANS_DATA_LEN_W-1:0]           s_ARLEN_o,
    output logic [TRANS_DATA_SIZE_W-1:0]          s_ARSIZE_o,
    output logic                                  s_ARVALID_o,
    input  logic                                  s_ARREADY_i,
    input  logic [TRANS_MST_ID_W-1:0]             s_RID_i,
    input  logic [DATA_WIDTH-1:0]                 s_RDATA_i,
    input  logic                                  s_RLAST_i,
    input  logic                                  s_RVALID_i,
    output logic                                  s_RREADY_o
);

    ar_state_t                     r_state;
    ar_state_t                     w_state_nxt;
    logic [MST_AMT-1:0]            w_eligible;
    logic [MST_ID_W-1:0]           w_start;
    logic [MST_ID_W-1:0]           w_winner;
    logic                          w_found;
    logic                          w_grant;
    int                            w_idx;
    logic                          w_fifo_full;
    logic                          w_fifo_empty;
    logic [MST_ID_W-1:0]           w_head;
    logic                          w_r_active;
    logic                          w_pop;
    logic [TRANS_MST_ID_W-1:0]     r_arid;
    logic [ADDR_WIDTH-1:0]         r_araddr;
    logic [TRANS_BURST_W-1:0]      r_arburst;
    logic [TRANS_DATA_LEN_W-1:0]   r_arlen;
    logic [TRANS_DATA_SIZE_W-1:0]  r_arsize;

    assign w_eligible = dsp_ARVALID_i & ~dsp_AR_outst_full_i;

`ifdef SA_RR_ARB_EN
    logic [MST_ID_W-1:0] r_rr_ptr;

    // Pointer holds the next search start, i.e. last winner + 1 mod MST_AMT.
    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            r_rr_ptr <= '0;
        end else if (w_grant) begin
            r_rr_ptr <= (int'(w_winner) == MST_AMT - 1) ? '0 : w_winner + 1'b1;
        end
    end

    assign w_start = r_rr_ptr;
`else
    assign w_start = '0;
`endif

    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int i = 0; i < MST_AMT; i++) begin
            w_idx = (int'(w_start) + i) % MST_AMT;
            if (!w_found && w_eligible[w_idx]) begin
                w_found  = 1'b1;
                w_winner = MST_ID_W'(w_idx);
            end
        end
    end

    // A full FIFO blocks the grant even when a pop lands in the same cycle.
    assign w_grant = (r_state == AR_IDLE) & w_found & ~w_fifo_full & ~ARESET_i;

    always_comb begin
        dsp_ARREADY_o = '0;
        for (int i = 0; i < MST_AMT; i++) begin
            dsp_ARREADY_o[i] = w_grant & (w_winner == MST_ID_W'(i));
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            AR_IDLE: if (w_grant)     w_state_nxt = AR_HOLD;
            AR_HOLD: if (s_ARREADY_i) w_state_nxt = AR_IDLE;
            default:                  w_state_nxt = AR_IDLE;
        endcase
    end

    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            r_state   <= AR_IDLE;
            r_arid    <= '0;
            r_araddr  <= '0;
            r_arburst <= '0;
            r_arlen   <= '0;
            r_arsize  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_arid    <= dsp_ARID_i[w_winner*TRANS_MST_ID_W +: TRANS_MST_ID_W];
                r_araddr  <= dsp_ARADDR_i[w_winner*ADDR_WIDTH +: ADDR_WIDTH];
                r_arburst <= dsp_ARBURST_i[w_winner*TRANS_BURST_W +: TRANS_BURST_W];
                r_arlen   <= dsp_ARLEN_i[w_winner*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
                r_arsize  <= dsp_ARSIZE_i[w_winner*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
            end
        end
    end

    assign s_ARVALID_o = (r_state == AR_HOLD);
    assign s_ARID_o    = r_arid;
    assign s_ARADDR_o  = r_araddr;
    assign s_ARBURST_o = r_arburst;
    assign s_ARLEN_o   = r_arlen;
    assign s_ARSIZE_o  = r_arsize;

    sa_outst_fifo #(
        .DEPTH (OUTSTANDING_AMT),
        .WIDTH (MST_ID_W)
    ) u_outst_fifo (
        .clk         (ACLK_i),
        .rst         (ARESET_i),
        .i_push      (w_grant),
        .i_push_data (w_winner),
        .i_pop       (w_pop),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_head      (w_head)
    );

    // R beats with no outstanding owner are stalled rather than dropped.
    assign w_r_active = ~w_fifo_empty & ~ARESET_i;
    assign s_RREADY_o = w_r_active & dsp_RREADY_i[w_head];
    assign w_pop      = s_RVALID_i & s_RREADY_o & s_RLAST_i;

    always_comb begin
        dsp_RVALID_o = '0;
        for (int i = 0; i < MST_AMT; i++) begin
            dsp_RVALID_o[i] = w_r_active & s_RVALID_i & (w_head == MST_ID_W'(i));
        end
    end

    assign dsp_RID_o   = {MST_AMT{s_RID_i}};
    assign dsp_RDATA_o = {MST_AMT{s_RDATA_i}};
    assign dsp_RLAST_o = {MST_AMT{s_RLAST_i}};

endmodule

`default_nettype wire

// File: tb/tb_sa_read_channel.sv
// ============================================================================
// Module   : tb_sa_read_channel
// Brief    : Directed self-checking bench for sa_read_channel (2 masters, depth 8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sa_read_channel;

    logic        ACLK_i = 1'b0;
    logic        ARESET_i;
    logic [9:0]  dsp_ARID_i;
    logic [63:0] dsp_ARADDR_i;
    logic [3:0]  dsp_ARBURST_i;
    logic [5:0]  dsp_ARLEN_i;
    logic [5:0]  dsp_ARSIZE_i;
    logic [1:0]  dsp_ARVALID_i;
    logic [1:0]  dsp_AR_outst_full_i;
    logic [1:0]  dsp_ARREADY_o;
    logic [9:0]  dsp_RID_o;
    logic [63:0] dsp_RDATA_o;
    logic [1:0]  dsp_RLAST_o;
    logic [1:0]  dsp_RVALID_o;
    logic [1:0]  dsp_RREADY_i;
    logic [4:0]  s_ARID_o;
    logic [31:0] s_ARADDR_o;
    logic [1:0]  s_ARBURST_o;
    logic [2:0]  s_ARLEN_o;
    logic [2:0]  s_ARSIZE_o;
    logic        s_ARVALID_o;
    logic        s_ARREADY_i;
    logic [4:0]  s_RID_i;
    logic [31:0] s_RDATA_i;
    logic        s_RLAST_i;
    logic        s_RVALID_i;
    logic        s_RREADY_o;

    int total = 0;
    int bad   = 0;

    sa_read_channel dut (
        .ACLK_i              (ACLK_i),
        .ARESET_i            (ARESET_i),
        .dsp_ARID_i          (dsp_ARID_i),
        .dsp_ARADDR_i        (dsp_ARADDR_i),
        .dsp_ARBURST_i       (dsp_ARBURST_i),
        .dsp_ARLEN_i         (dsp_ARLEN_i),
        .dsp_ARSIZE_i        (dsp_ARSIZE_i),
        .dsp_ARVALID_i       (dsp_ARVALID_i),
        .dsp_AR_outst_full_i (dsp_AR_outst_full_i),
        .dsp_ARREADY_o       (dsp_ARREADY_o),
        .dsp_RID_o           (dsp_RID_o),
        .dsp_RDATA_o         (dsp_RDATA_o),
        .dsp_RLAST_o         (dsp_RLAST_o),
        .dsp_RVALID_o        (dsp_RVALID_o),
        .dsp_RREADY_i        (dsp_RREADY_i),
        .s_ARID_o            (s_ARID_o),
        .s_ARADDR_o          (s_ARADDR_o),
        .s_ARBURST_o         (s_ARBURST_o),
        .s_ARLEN_o           (s_ARLEN_o),
        .s_ARSIZE_o          (s_ARSIZE_o),
        .s_ARVALID_o         (s_ARVALID_o),
        .s_ARREADY_i         (s_ARREADY_i),
        .s_RID_i             (s_RID_i),
        .s_RDATA_i           (s_RDATA_i),
        .s_RLAST_i           (s_RLAST_i),
        .s_RVALID_i          (s_RVALID_i),
        .s_RREADY_o          (s_RREADY_o)
    );

    always #5 ACLK_i = ~ACLK_i;

    // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
    task automatic cyc();
        @(posedge ACLK_i);
        #1;
    endtask

    task automatic test_reset();
        ARESET_i      = 1'b1;
        dsp_ARVALID_i = 2'b11;
        s_RVALID_i    = 1'b1;
        dsp_RREADY_i  = 2'b11;
        cyc();
        cyc();
        @(negedge ACLK_i);
        total++; if (s_ARVALID_o !== 1'b0) begin bad++; $display("FAIL rst_arvalid got=%b want=0", s_ARVALID_o); end
        total++; if ({s_ARID_o, s_ARADDR_o, s_ARBURST_o, s_ARLEN_o, s_ARSIZE_o} !== 45'd0) begin
            bad++; $display("FAIL rst_ar_fields got=%h want=0", {s_ARID_o, s_ARADDR_o, s_ARBURST_o, s_ARLEN_o, s_ARSIZE_o}); end
        total++; if (dsp_ARREADY_o !== 2'b00) begin bad++; $display("FAIL rst_arready got=%b want=00", dsp_ARREADY_o); end
        total++; if (dsp_RVALID_o !== 2'b00) begin bad++; $display("FAIL rst_rvalid got=%b want=00", dsp_RVALID_o); end
        total++; if (s_RREADY_o !== 1'b0) begin bad++; $display("FAIL rst_rready got=%b want=0", s_RREADY_o); end
        cyc();
        ARESET_i      = 1'b0;
        dsp_ARVALID_i = 2'b00;
        s_RVALID_i    = 1'b0;
        dsp_RREADY_i  = 2'b00;
        @(negedge ACLK_i);
        s_RVALID_i = 1'b1;
        dsp_RREADY_i = 2'b11;
        #1;
        total++; if (s_RREADY_o !== 1'b0) begin bad++; $display("FAIL rst_empty_rready got=%b want=0", s_RREADY_o); end
        cyc();
        s_RVALID_i   = 1'b0;
        dsp_RREADY_i = 2'b00;
    endtask

    task automatic test_single_read();
        logic [31:0] d;
        s_ARREADY_i   = 1'b1;
        dsp_ARVALID_i = 2'b01;
        @(negedge ACLK_i);
        total++; if (dsp_ARREADY_o !== 2'b01) begin bad++; $display("FAIL single_arready got=%b want=01", dsp_ARREADY_o); end
        total++; if (s_ARVALID_o !== 1'b0) begin bad++; $display("FAIL single_arvalid_n got=%b want=0", s_ARVALID_o); end
        cyc();
        dsp_ARVALID_i = 2'b00;
        @(negedge ACLK_i);
        total++; if (s_ARVALID_o !== 1'b1) begin bad++; $display("FAIL single_arvalid_n1 got=%b want=1", s_ARVALID_o); end
        total++; if ({s_ARID_o, s_ARADDR_o, s_ARBURST_o, s_ARLEN_o, s_ARSIZE_o} !== {5'h01, 32'h0000_1000, 2'b01, 3'd3, 3'd2}) begin
            bad++; $display("FAIL single_ar_fields got=%h want=%h", {s_ARID_o, s_ARADDR_o, s_ARBURST_o, s_ARLEN_o, s_ARSIZE_o},
                            {5'h01, 32'h0000_1000, 2'b01, 3'd3, 3'd2}); end
        cyc();
        dsp_RREADY_i = 2'b11;
        s_RID_i      = 5'h01;
        for (int b = 0; b < 4; b++) begin
            d          = 32'hA000_0000 + b;
            s_RVALID_i = 1'b1;
            s_RDATA_i  = d;
            s_RLAST_i  = (b == 3);
            @(negedge ACLK_i);
            total++; if (dsp_RVALID_o !== 2'b01) begin bad++; $display("FAIL single_rvalid beat=%0d got=%b want=01", b, dsp_RVALID_o); end
            total++; if (s_RREADY_o !== 1'b1) begin bad++; $display("FAIL single_rready beat=%0d got=%b want=1", b, s_RREADY_o); end
            total++; if (dsp_RDATA_o !== {d, d}) begin bad++; $display("FAIL single_rdata beat=%0d got=%h want=%h", b, dsp_RDATA_o, {d, d}); end
            cyc();
        end
        s_RLAST_i = 1'b0;
        @(negedge ACLK_i);
        total++; if ({dsp_RVALID_o, s_RREADY_o} !== 3'b000) begin bad++; $display("FAIL single_drained got=%b want=000", {dsp_RVALID_o, s_RREADY_o}); end
        cyc();
        s_RVALID_i   = 1'b0;
        dsp_RREADY_i = 2'b00;
    endtask

    task automatic test_contention();
        logic [1:0] exp_q [4];
        logic [1:0] exp;
        ARESET_i = 1'b1;
        cyc();
        ARESET_i      = 1'b0;
        s_ARREADY_i   = 1'b1;
        dsp_ARVALID_i = 2'b11;
        for (int k = 0; k < 4; k++) begin
`ifdef SA_RR_ARB_EN
            exp = (k % 2 == 1) ? 2'b10 : 2'b01;
`else
            exp = 2'b01;
`endif
            exp_q[k] = exp;
            @(negedge ACLK_i);
            total++; if (dsp_ARREADY_o !== exp) begin bad++; $display("FAIL contend_grant k=%0d got=%b want=%b", k, dsp_ARREADY_o, exp); end
            cyc();
            if (k == 3) dsp_ARVALID_i = 2'b00;
            @(negedge ACLK_i);
            total++; if (s_ARID_o !== ((exp == 2'b10) ? 5'h02 : 5'h01)) begin
                bad++; $display("FAIL contend_arid k=%0d got=%h want=%h", k, s_ARID_o, (exp == 2'b10) ? 5'h02 : 5'h01); end
            cyc();
        end
        dsp_RREADY_i = 2'b11;
        s_RVALID_i   = 1'b1;
        s_RLAST_i    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge ACLK_i);
            total++; if (dsp_RVALID_o !== exp_q[k]) begin bad++; $display("FAIL contend_route k=%0d got=%b want=%b", k, dsp_RVALID_o, exp_q[k]); end
            cyc();
        end
        s_RVALID_i   = 1'b0;
        s_RLAST_i    = 1'b0;
        dsp_RREADY_i = 2'b00;
    endtask

    task automatic test_outst_mask();
        s_ARREADY_i         = 1'b1;
        dsp_ARVALID_i       = 2'b11;
        dsp_AR_outst_full_i = 2'b01;
        @(negedge ACLK_i);
        total++; if (dsp_ARREADY_o !== 2'b10) begin bad++; $display("FAIL mask_grant got=%b want=10", dsp_ARREADY_o); end
        cyc();
        dsp_ARVALID_i       = 2'b00;
        dsp_AR_outst_full_i = 2'b00;
        cyc();
        dsp_RREADY_i = 2'b11;
        s_RVALID_i   = 1'b1;
        s_RLAST_i    = 1'b1;
        @(negedge ACLK_i);
        total++; if (dsp_RVALID_o !== 2'b10) begin bad++; $display("FAIL mask_route got=%b want=10", dsp_RVALID_o); end
        cyc();
        s_RVALID_i   = 1'b0;
        s_RLAST_i    = 1'b0;
        dsp_RREADY_i = 2'b00;
    endtask

    task automatic test_full();
        s_ARREADY_i   = 1'b1;
        dsp_ARVALID_i = 2'b01;
        for (int k = 0; k < 8; k++) begin
            @(negedge ACLK_i);
            total++; if (dsp_ARREADY_o !== 2'b01) begin bad++; $display("FAIL full_fill k=%0d got=%b want=01", k, dsp_ARREADY_o); end
            cyc();
            cyc();
        end
        @(negedge ACLK_i);
        total++; if (dsp_ARREADY_o !== 2'b00) begin bad++; $display("FAIL full_block got=%b want=00", dsp_ARREADY_o); end
        cyc();
        s_RVALID_i   = 1'b1;
        s_RLAST_i    = 1'b1;
        dsp_RREADY_i = 2'b01;
        @(negedge ACLK_i);
        total++; if (dsp_ARREADY_o !== 2'b00) begin bad++; $display("FAIL full_pop_same_cycle got=%b want=00", dsp_ARREADY_o); end
        total++; if (s_RREADY_o !== 1'b1) begin bad++; $display("FAIL full_pop_rready got=%b want=1", s_RREADY_o); end
        cyc();
        s_RVALID_i = 1'b0;
        @(negedge ACLK_i);
        total++; if (dsp_ARREADY_o !== 2'b01) begin bad++; $display("FAIL full_resume got=%b want=01", dsp_ARREADY_o); end
        cyc();
        dsp_ARVALID_i = 2'b00;
        cyc();
        s_RVALID_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge ACLK_i);
            total++; if (dsp_RVALID_o !== 2'b01) begin bad++; $display("FAIL full_drain k=%0d got=%b want=01", k, dsp_RVALID_o); end
            cyc();
        end
        @(negedge ACLK_i);
        total++; if (dsp_RVALID_o !== 2'b00) begin bad++; $display("FAIL full_empty got=%b want=00", dsp_RVALID_o); end
        cyc();
        s_RVALID_i   = 1'b0;
        s_RLAST_i    = 1'b0;
        dsp_RREADY_i = 2'b00;
    endtask

    task automatic test_ar_stall();
        s_ARREADY_i   = 1'b0;
        dsp_ARVALID_i = 2'b10;
        @(negedge ACLK_i);
        total++; if (dsp_ARREADY_o !== 2'b10) begin bad++; $display("FAIL stall_grant got=%b want=10", dsp_ARREADY_o); end
        cyc();
        dsp_ARVALID_i = 2'b11;
        for (int k = 0; k < 5; k++) begin
            @(negedge ACLK_i);
            total++; if ({s_ARVALID_o, s_ARID_o, s_ARADDR_o} !== {1'b1, 5'h02, 32'h0000_2000}) begin
                bad++; $display("FAIL stall_hold k=%0d got=%h want=%h", k, {s_ARVALID_o, s_ARID_o, s_ARADDR_o}, {1'b1, 5'h02, 32'h0000_2000}); end
            total++; if (dsp_ARREADY_o !== 2'b00) begin bad++; $display("FAIL stall_no_grant k=%0d got=%b want=00", k, dsp_ARREADY_o); end
            cyc();
        end
        dsp_ARVALID_i = 2'b00;
        s_ARREADY_i   = 1'b1;
        cyc();
        @(negedge ACLK_i);
        total++; if (s_ARVALID_o !== 1'b0) begin bad++; $display("FAIL stall_release got=%b want=0", s_ARVALID_o); end
        cyc();
    endtask

    task automatic test_r_backpressure();
        s_RVALID_i   = 1'b1;
        s_RLAST_i    = 1'b1;
        s_RDATA_i    = 32'h5555_AAAA;
        dsp_RREADY_i = 2'b01;
        @(negedge ACLK_i);
        total++; if (s_RREADY_o !== 1'b0) begin bad++; $display("FAIL bp_rready got=%b want=0", s_RREADY_o); end
        total++; if (dsp_RVALID_o !== 2'b10) begin bad++; $display("FAIL bp_rvalid got=%b want=10", dsp_RVALID_o); end
        cyc();
        @(negedge ACLK_i);
        total++; if (dsp_RVALID_o !== 2'b10) begin bad++; $display("FAIL bp_held got=%b want=10", dsp_RVALID_o); end
        cyc();
        dsp_RREADY_i = 2'b10;
        @(negedge ACLK_i);
        total++; if (s_RREADY_o !== 1'b1) begin bad++; $display("FAIL bp_release got=%b want=1", s_RREADY_o); end
        cyc();
        @(negedge ACLK_i);
        total++; if (dsp_RVALID_o !== 2'b00) begin bad++; $display("FAIL bp_popped got=%b want=00", dsp_RVALID_o); end
        cyc();
        s_RVALID_i   = 1'b0;
        s_RLAST_i    = 1'b0;
        dsp_RREADY_i = 2'b00;
    endtask

    task automatic test_reset_mid_burst();
        s_ARREADY_i   = 1'b1;
        dsp_ARVALID_i = 2'b01;
        @(negedge ACLK_i);
        total++; if (dsp_ARREADY_o !== 2'b01) begin bad++; $display("FAIL mid_grant got=%b want=01", dsp_ARREADY_o); end
        cyc();
        dsp_ARVALID_i = 2'b00;
        cyc();
        dsp_RREADY_i = 2'b11;
        s_RVALID_i   = 1'b1;
        s_RLAST_i    = 1'b0;
        s_RDATA_i    = 32'hB000_0001;
        @(negedge ACLK_i);
        total++; if (dsp_RVALID_o !== 2'b01) begin bad++; $display("FAIL mid_beat1 got=%b want=01", dsp_RVALID_o); end
        cyc();
        s_RDATA_i = 32'hB000_0002;
        ARESET_i  = 1'b1;
        @(negedge ACLK_i);
        total++; if ({dsp_RVALID_o, s_RREADY_o} !== 3'b000) begin bad++; $display("FAIL mid_in_reset got=%b want=000", {dsp_RVALID_o, s_RREADY_o}); end
        cyc();
        ARESET_i = 1'b0;
        @(negedge ACLK_i);
        total++; if ({s_ARVALID_o, s_ARID_o, s_ARADDR_o, s_ARLEN_o} !== 41'd0) begin
            bad++; $display("FAIL mid_ar_cleared got=%h want=0", {s_ARVALID_o, s_ARID_o, s_ARADDR_o, s_ARLEN_o}); end
        total++; if ({dsp_RVALID_o, s_RREADY_o, dsp_ARREADY_o} !== 5'b0) begin
            bad++; $display("FAIL mid_r_cleared got=%b want=00000", {dsp_RVALID_o, s_RREADY_o, dsp_ARREADY_o}); end
        cyc();
        s_RVALID_i   = 1'b0;
        dsp_RREADY_i = 2'b00;
    endtask

    initial begin
        ARESET_i            = 1'b1;
        dsp_ARID_i          = {5'h02, 5'h01};
        dsp_ARADDR_i        = {32'h0000_2000, 32'h0000_1000};
        dsp_ARBURST_i       = {2'b01, 2'b01};
        dsp_ARLEN_i         = {3'd0, 3'd3};
        dsp_ARSIZE_i        = {3'd2, 3'd2};
        dsp_ARVALID_i       = 2'b00;
        dsp_AR_outst_full_i = 2'b00;
        dsp_RREADY_i        = 2'b00;
        s_ARREADY_i         = 1'b0;
        s_RID_i             = 5'h00;
        s_RDATA_i           = 32'h0;
        s_RLAST_i           = 1'b0;
        s_RVALID_i          = 1'b0;

        test_reset();
        test_single_read();
        test_contention();
        test_outst_mask();
        test_full();
        test_ar_stall();
        test_r_backpressure();
        test_reset_mid_burst();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

`default_nettype wire
